// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// one bit per clock under a start/busy/done handshake.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q;
   logic [WIDTH-1:0] sa_d;
   logic             carry_q, carry_d;
   logic             s_d;
   logic             last_d;
   logic [CW-1:0]    cnt_q;

   always_comb begin
      s_d     = sa_q[0] ^ sb_q[0] ^ carry_q;
      carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
      last_d  = (cnt_q == CW'(WIDTH - 1));
   end

   // SA doubles as the result shift register: each result bit fills the MSB
   // position vacated by the operand bit just consumed.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sa_d = s_d;
      end else begin : g_wn
         assign sa_d = {s_d, sa_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sa_q    <= sa_d;
               sb_q    <= sb_q >> 1;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + 1'b1;
               if (last_d) begin
                  // carry_q here is the carry into the MSB
                  sum      <= sa_d;
                  cout     <= carry_d;
                  overflow <= carry_q ^ carry_d;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance for timing and arithmetic,
// WIDTH=1 instance checked against the full-adder truth table.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, sub8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, cout8, ov8;
   logic [7:0] sum8;
   logic       start1 = 1'b0, sub1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
   logic       busy1, done1, cout1, ov1, sum1;

   int n_cmp = 0;
   int n_err = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ov1)
   );

   always #5 clk = ~clk;

   // Launches one operation from a negedge and returns at the negedge where done
   // is seen (or after a 20-cycle budget). poke>0 requests a restart mid-run.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input int poke, output int lat, output int bcnt,
                       output bit moved, output bit first_busy);
      logic [7:0] s0;
      s0 = sum8;
      lat = 0; bcnt = 0; moved = 1'b0;
      start8 = 1'b1; a8 = ia; b8 = ib; sub8 = isub;
      @(negedge clk);
      start8 = 1'b0;
      first_busy = busy8;
      while (done8 !== 1'b1 && lat < 20) begin
         if (busy8 === 1'b1) bcnt++;
         if (sum8 !== s0) moved = 1'b1;
         @(negedge clk);
         lat++;
         if (lat == poke) begin
            start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
         end else if (lat == poke + 1) begin
            start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy8, done8, sum8, cout8, ov8} !== 12'h000) begin
         n_err++; $display("FAIL reset_w8: got %h want 000", {busy8, done8, sum8, cout8, ov8});
      end
      n_cmp++;
      if ({busy1, done1, sum1, cout1, ov1} !== 5'b0) begin
         n_err++; $display("FAIL reset_w1: got %b want 00000", {busy1, done1, sum1, cout1, ov1});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_arith(input string name, input logic [7:0] ia, input logic [7:0] ib,
                             input logic isub, input logic [7:0] es, input logic ec,
                             input logic eo);
      int lat, bcnt; bit moved, fb;
      run8(ia, ib, isub, 0, lat, bcnt, moved, fb);
      n_cmp++;
      if (lat != 8) begin n_err++; $display("FAIL %s_latency: got %0d want 8", name, lat); end
      n_cmp++;
      if (bcnt != 8) begin n_err++; $display("FAIL %s_busy_cycles: got %0d want 8", name, bcnt); end
      n_cmp++;
      if (moved) begin n_err++; $display("FAIL %s_sum_stable: sum changed mid-run want held", name); end
      n_cmp++;
      if ({sum8, cout8, ov8, busy8} !== {es, ec, eo, 1'b0}) begin
         n_err++;
         $display("FAIL %s_result: got sum=%h cout=%b ov=%b busy=%b want sum=%h cout=%b ov=%b busy=0",
                  name, sum8, cout8, ov8, busy8, es, ec, eo);
      end
      @(negedge clk);
      n_cmp++;
      if (done8 !== 1'b0 || sum8 !== es) begin
         n_err++; $display("FAIL %s_done_pulse: got done=%b sum=%h want done=0 sum=%h", name, done8, sum8, es);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt; bit moved, fb;
      run8(8'h10, 8'h20, 1'b0, 3, lat, bcnt, moved, fb);
      n_cmp++;
      if (lat != 8 || sum8 !== 8'h30 || cout8 !== 1'b0 || ov8 !== 1'b0) begin
         n_err++; $display("FAIL ignore_start: got lat=%0d sum=%h cout=%b ov=%b want lat=8 sum=30 cout=0 ov=0",
                           lat, sum8, cout8, ov8);
      end
      // start raised in the done cycle itself
      run8(8'h01, 8'h02, 1'b0, 0, lat, bcnt, moved, fb);
      n_cmp++;
      if (fb !== 1'b1) begin n_err++; $display("FAIL b2b_no_gap: got busy=%b want 1", fb); end
      n_cmp++;
      if (lat != 8 || sum8 !== 8'h03 || moved) begin
         n_err++; $display("FAIL b2b_result: got lat=%0d sum=%h moved=%b want lat=8 sum=03 moved=0", lat, sum8, moved);
      end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int seen;
      start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({busy8, done8, sum8, cout8, ov8} !== 12'h000) begin
         n_err++; $display("FAIL abort_outputs: got %h want 000", {busy8, done8, sum8, cout8, ov8});
      end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 === 1'b1 || busy8 === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_width1();
      // packed {sum, cout, overflow} indexed by {a, b, sub}
      logic [2:0] exp1 [8] = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b100, 3'b110, 3'b011, 3'b010};
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         start1 = 1'b1; a1 = v[2]; b1 = v[1]; sub1 = v[0];
         @(negedge clk);
         start1 = 1'b0;
         n_cmp++;
         if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_err++; $display("FAIL w1_busy_%0d: got busy=%b done=%b want busy=1 done=0", i, busy1, done1);
         end
         @(negedge clk);
         n_cmp++;
         if (done1 !== 1'b1 || busy1 !== 1'b0 || {sum1, cout1, ov1} !== exp1[i]) begin
            n_err++; $display("FAIL w1_result_%0d: got done=%b busy=%b s/c/v=%b want done=1 busy=0 s/c/v=%b",
                              i, done1, busy1, {sum1, cout1, ov1}, exp1[i]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_arith("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      test_arith("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      test_arith("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      test_arith("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
      test_arith("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      test_arith("sub_00_00", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      test_back_to_back();
      test_abort();
      test_width1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
